output_buffer: RTL and testbench
================================

# output_buffer

Elastic FIFO stage between the control unit and the output unit. Each CU value arrives over a 4-phase req/ack handshake and is queued in a DEPTH-entry buffer. Queued values are replayed in order to the output unit over its own 4-phase handshake (out_req/out_data/out_ack). The CU therefore stalls only when the buffer is full, not on every display.

## Interface
- DW, 16, data width, matching the output unit.
- DEPTH, 4, number of buffer entries; power of two, ≥2.
- AW, $clog2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  active-low reset, synchronous to clk. One clock; reset is synchronous and active-low.
- cu_req  in  1  CU write request; cu_data must be stable while high.
- cu_data  in  DW  value to queue.
- cu_ack  out  1  write accepted; held until cu_req falls.
- out_req  out  1  request to output unit.
- out_data  out  DW  value being presented; registered.
- out_ack  in  1  acknowledge from output unit.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
Reset values:
- cu_ack=0, out_req=0, out_data=0, count=0, full=0, empty=1.
- Pointers are zeroed. Both FSMs go to their idle states.

Upstream FSM (U_IDLE, U_ACK):
- U_IDLE: if cu_req && !full, write cu_data at wr_ptr, advance wr_ptr, set cu_ack<=1, go to U_ACK. If full, cu_ack stays 0 and the CU waits.
- U_ACK: hold cu_ack=1. When cu_req==0, set cu_ack<=0 and return to U_IDLE. Exactly one entry is written per handshake.

Downstream FSM (D_IDLE, D_REQ, D_WAIT):
- D_IDLE: if !empty && !out_ack, load out_data<=mem[rd_ptr], set out_req<=1, go to D_REQ.
- D_REQ: hold out_req and out_data. When out_ack==1, set out_req<=0, advance rd_ptr (pop), go to D_WAIT.
- D_WAIT: when out_ack==0, go to D_IDLE. This rule is mandatory because the output unit keeps out_ack high for up to 2 cycles after req falls.

Occupancy and pointers:
- count is incremented on push, decremented on pop, unchanged when both happen on the same edge.
- full and empty are decoded from count, registered with it.
- Pointers wrap modulo DEPTH; DEPTH is a power of two, so this is natural AW-bit overflow.

Ordering and data:
- Output order equals acceptance order; no drops, no duplicates.
- Push when full is impossible by construction. Pop when empty is impossible by construction.

## Timing
- All state changes occur on the rising edge of clk.
- cu_req sampled high at edge k with buffer not full: after edge k, cu_ack=1 and count is incremented.
- Buffer empty, out_ack low, cu_req sampled at edge k: out_req=1 with valid out_data after edge k+1. Push-to-present latency is 2 cycles.
- out_ack sampled high at edge m: out_req=0 and count decremented after edge m.
- Next out_req no earlier than 1 cycle after out_ack is sampled low.
- Minimum upstream handshake: 2 cycles per value (ack rise, then req-low observed).
- Reset asserted at any edge, including mid-handshake: all outputs take reset values after that edge. Buffered data is discarded; a partially acknowledged CU transfer is lost.

## Structure
- Shared package/header: state encodings U_IDLE/U_ACK and D_IDLE/D_REQ/D_WAIT, and the default DW.
- Sub-module output_buffer_mem: DEPTH×DW register array with one synchronous write port and one combinational read port (rd_addr → rd_data), no reset on storage.
- FSMs, pointers and count stay in output_buffer.

## Test plan
- Reset: hold rst_b=0 for 2 cycles with cu_req=1 → cu_ack=0, out_req=0, count=0, empty=1 throughout. Release: cu_ack rises 1 cycle later.
- Single value: push 42 with an output_unit model attached → cu_ack after 1 cycle, out_req with out_data=42 one cycle later, exactly one "OUT> 42", count returns to 0.
- Full/backpressure: out_ack held 0, push 1,2,3,4 → count=4, full=1. The 5th cu_req (value 5) gets no cu_ack. After one pop, cu_ack rises and the drained sequence is 1,2,3,4,5.
- Wrap and order: stream 100..109 through DEPTH=4 against a randomized-delay ack model → output exactly 100..109 in order, count ends 0.
- Simultaneous events and lingering ack:
  - Push accepted on the same edge as a pop → count unchanged.
  - out_ack held high 2 cycles after out_req falls → no new out_req until out_ack is sampled low.
- Mid-operation reset: assert rst_b=0 while out_req=1 and count=3 → after the edge, out_req=0, count=0, and no further values are displayed.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// Shared types for the output buffer: handshake FSM state encodings and
// default sizing.
package output_buffer_pkg;

  localparam int DW_DEFAULT    = 16;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic {
    U_IDLE = 1'b0,
    U_ACK  = 1'b1
  } u_state_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_REQ  = 2'd1,
    D_WAIT = 2'd2
  } d_state_e;

endpackage

// File: rtl/output_buffer_mem.sv
// DEPTH x DW storage: one synchronous write port, one combinational read port.
// Storage is intentionally not reset; occupancy tracking guards every read.
module output_buffer_mem #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/output_buffer.sv
// Elastic FIFO between the control unit and the output unit, with a 4-phase
// req/ack handshake on each side and registered status outputs.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter  int DW    = DW_DEFAULT,
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          cu_req,
  input  logic [DW-1:0] cu_data,
  output logic          cu_ack,
  output logic          out_req,
  output logic [DW-1:0] out_data,
  input  logic          out_ack,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output u_state_e      u_state_o,
  output d_state_e      d_state_o
);

  // Handshake (both sides, 4-phase): the requester raises req with data stable,
  // the responder raises ack, the requester drops req, the responder drops ack.
  // One value moves per full cycle; a value is pushed when cu_ack rises and
  // popped on the edge out_ack is first seen high while out_req is up.

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  u_state_e      u_state_q, u_state_d;
  d_state_e      d_state_q, d_state_d;
  logic          cu_ack_q, cu_ack_d;
  logic          out_req_q, out_req_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push, pop;
  logic [DW-1:0] rd_data;

  output_buffer_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .we_i      (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (cu_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    u_state_d = u_state_q;
    cu_ack_d  = cu_ack_q;
    push      = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        if (cu_req && !full_q) begin
          push      = 1'b1;
          cu_ack_d  = 1'b1;
          u_state_d = U_ACK;
        end
      end
      U_ACK: begin
        if (!cu_req) begin
          cu_ack_d  = 1'b0;
          u_state_d = U_IDLE;
        end
      end
    endcase
  end

  // D_WAIT absorbs an out_ack that lingers after out_req falls.
  always_comb begin
    d_state_d  = d_state_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    pop        = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        if (!empty_q && !out_ack) begin
          out_req_d  = 1'b1;
          out_data_d = rd_data;
          d_state_d  = D_REQ;
        end
      end
      D_REQ: begin
        if (out_ack) begin
          out_req_d = 1'b0;
          pop       = 1'b1;
          d_state_d = D_WAIT;
        end
      end
      D_WAIT: begin
        if (!out_ack) begin
          d_state_d = D_IDLE;
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      u_state_q  <= U_IDLE;
      d_state_q  <= D_IDLE;
      cu_ack_q   <= 1'b0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      u_state_q  <= u_state_d;
      d_state_q  <= d_state_d;
      cu_ack_q   <= cu_ack_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  assign cu_ack    = cu_ack_q;
  assign out_req   = out_req_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign u_state_o = u_state_q;
  assign d_state_o = d_state_q;

endmodule

// File: tb/tb_output_buffer.sv
// Bench for output_buffer: CU driver, randomized output-unit responder,
// order scoreboard and a per-cycle handshake/occupancy reference model.
module tb_output_buffer;
  import output_buffer_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_b;
  logic          cu_req;
  logic [DW-1:0] cu_data;
  logic          cu_ack;
  logic          out_req;
  logic [DW-1:0] out_data;
  logic          out_ack;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  u_state_e      u_state;
  d_state_e      d_state;

  output_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .cu_req    (cu_req),
    .cu_data   (cu_data),
    .cu_ack    (cu_ack),
    .out_req   (out_req),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .u_state_o (u_state),
    .d_state_o (d_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] disp_q[$];
  int            disp_n = 0;

  // ---------------- output-unit responder ----------------
  bit ou_stall = 1'b0;
  int ou_max_dly = 0;
  int ou_min_linger = 0;
  int ou_max_linger = 0;
  int ou_dly;
  bit ou_dly_set = 1'b0;
  int ou_linger = 0;

  initial begin
    out_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_b) begin
        out_ack    = 1'b0;
        ou_dly_set = 1'b0;
      end else if (out_ack) begin
        if (!out_req) begin
          if (ou_linger == 0) out_ack = 1'b0;
          else ou_linger--;
        end
      end else if (out_req && !ou_stall) begin
        if (!ou_dly_set) begin
          ou_dly     = $urandom_range(ou_max_dly, 0);
          ou_dly_set = 1'b1;
        end
        if (ou_dly == 0) begin
          out_ack    = 1'b1;
          ou_dly_set = 1'b0;
          ou_linger  = $urandom_range(ou_max_linger, ou_min_linger);
          disp_q.push_back(out_data);
          disp_n++;
          $display("OUT> %0d", out_data);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL out_extra: got %0d expected no value", out_data);
          end else begin
            chk("out_order", out_data, exp_q.pop_front());
          end
        end else begin
          ou_dly--;
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // Inputs captured at a falling edge are what the next rising edge samples.
  logic          rst_p = 1'b0;
  logic          cu_req_p = 1'b0;
  logic [DW-1:0] cu_data_p = '0;
  logic          ack_p = 1'b0;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] pop_v;
  bit            m_ack = 1'b0;
  bit            m_req = 1'b0;
  bit            m_hold = 1'b0;
  int            both_cnt = 0;

  always @(negedge clk) begin
    int  old_n;
    bit  do_push, do_pop;
    if (!rst_p) begin
      m_q.delete();
      m_ack  = 1'b0;
      m_req  = 1'b0;
      m_hold = 1'b0;
      m_data = '0;
    end else begin
      old_n   = m_q.size();
      do_push = !m_ack && cu_req_p && (old_n < DEPTH);
      do_pop  = 1'b0;
      if (m_ack && !cu_req_p) m_ack = 1'b0;
      if (m_req) begin
        if (ack_p) begin
          m_req  = 1'b0;
          m_hold = 1'b1;
          do_pop = 1'b1;
        end
      end else if (m_hold) begin
        if (!ack_p) m_hold = 1'b0;
      end else if (old_n > 0 && !ack_p) begin
        m_req  = 1'b1;
        m_data = m_q[0];
      end
      if (do_pop) pop_v = m_q.pop_front();
      if (do_push) begin
        m_q.push_back(cu_data_p);
        m_ack = 1'b1;
      end
      if (do_push && do_pop) both_cnt++;
    end
    chk("m_cu_ack",   cu_ack,   m_ack);
    chk("m_out_req",  out_req,  m_req);
    chk("m_out_data", out_data, m_data);
    chk("m_count",    count,    m_q.size());
    chk("m_full",     full,     m_q.size() == DEPTH);
    chk("m_empty",    empty,    m_q.size() == 0);
    rst_p     = rst_b;
    cu_req_p  = cu_req;
    cu_data_p = cu_data;
    ack_p     = out_ack;
  end

  // ---------------- CU driver tasks ----------------
  task automatic cu_push(input logic [DW-1:0] v);
    int k;
    cu_data = v;
    cu_req  = 1'b1;
    k = 0;
    do begin tick(); k++; end while (cu_ack !== 1'b1 && k < 200);
    if (cu_ack !== 1'b1) begin
      chk("cu_ack_timeout", cu_ack, 1);
      cu_req = 1'b0;
      return;
    end
    exp_q.push_back(v);
    cu_req = 1'b0;
    k = 0;
    do begin tick(); k++; end while (cu_ack !== 1'b0 && k < 200);
    if (cu_ack !== 1'b0) chk("cu_ack_release", cu_ack, 0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_req !== 1'b0 || out_ack !== 1'b0) && k < 1000) begin
      tick();
      k++;
    end
    chk("drain_done", (exp_q.size() == 0) && (out_req === 1'b0), 1);
    chk("drain_count", count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n0;
    int k;
    rst_b   = 1'b0;
    cu_req  = 1'b1;
    cu_data = 16'd7;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_cu_ack", cu_ack, 0);
      chk("rst_out_req", out_req, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_d_state", d_state, D_IDLE);
    end
    rst_b = 1'b1;
    tick();
    chk("ack_after_release", cu_ack, 1);
    chk("u_state_ack", u_state, U_ACK);
    exp_q.push_back(16'd7);
    cu_req = 1'b0;
    k = 0;
    do begin tick(); k++; end while (cu_ack !== 1'b0 && k < 50);
    wait_drain();

    // single value: push-to-present latency of two edges
    n0 = disp_n;
    cu_data = 16'd42;
    cu_req  = 1'b1;
    tick();
    chk("single_cu_ack", cu_ack, 1);
    chk("single_count", count, 1);
    exp_q.push_back(16'd42);
    cu_req = 1'b0;
    tick();
    chk("single_out_req", out_req, 1);
    chk("single_out_data", out_data, 42);
    wait_drain();
    chk("single_disp_n", disp_n - n0, 1);
    chk("single_disp_val", disp_q[disp_q.size()-1], 42);

    // full and backpressure
    ou_stall = 1'b1;
    n0 = disp_n;
    for (int v = 1; v <= 4; v++) cu_push(v[DW-1:0]);
    tick(2);
    chk("full_count", count, 4);
    chk("full_flag", full, 1);
    cu_data = 16'd5;
    cu_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_no_ack", cu_ack, 0);
    end
    ou_stall = 1'b0;
    k = 0;
    do begin tick(); k++; end while (cu_ack !== 1'b1 && k < 50);
    chk("full_ack_after_pop", cu_ack, 1);
    exp_q.push_back(16'd5);
    cu_req = 1'b0;
    wait_drain();
    chk("full_disp_n", disp_n - n0, 5);
    for (int j = 0; j < 5; j++) chk($sformatf("full_seq%0d", j), disp_q[n0+j], j + 1);

    // wrap and order with randomized ack delay
    ou_max_dly    = 3;
    ou_max_linger = 2;
    n0 = disp_n;
    for (int v = 100; v <= 109; v++) cu_push(v[DW-1:0]);
    wait_drain();
    chk("wrap_disp_n", disp_n - n0, 10);
    for (int j = 0; j < 10; j++) chk($sformatf("wrap_seq%0d", j), disp_q[n0+j], 100 + j);

    // out_ack lingers two cycles after out_req falls
    ou_max_dly    = 0;
    ou_min_linger = 2;
    ou_max_linger = 2;
    for (int v = 200; v < 204; v++) cu_push(v[DW-1:0]);
    wait_drain();

    // randomized traffic
    ou_min_linger = 0;
    ou_max_linger = 2;
    ou_max_dly    = 4;
    for (int i = 0; i < 60; i++) begin
      tick($urandom_range(2, 0));
      cu_push($urandom_range(16'hFFFF, 0));
    end
    wait_drain();
    chk("push_pop_same_edge_seen", both_cnt > 0, 1);

    // reset while a value is presented and three are buffered
    ou_stall = 1'b1;
    for (int v = 300; v < 303; v++) cu_push(v[DW-1:0]);
    tick(2);
    chk("mid_pre_out_req", out_req, 1);
    chk("mid_pre_count", count, 3);
    rst_b = 1'b0;
    tick();
    chk("mid_out_req", out_req, 0);
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    exp_q.delete();
    n0 = disp_n;
    rst_b = 1'b1;
    ou_stall = 1'b0;
    tick(20);
    chk("mid_no_output", disp_n, n0);
    chk("mid_count_after", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
